// File: rtl/pong_round_ctrl.sv
// Game-round sequencer: serve delay, live play, post-point hold and game-over with score/winner tracking.
// Outputs are registered and appear one clk after the frame tick or start edge that caused them; there is no backpressure.
// Defining PONG_PAUSE_EN adds a pause input that freezes frame ticks and holds the ball still.
module pong_round_ctrl #(
   parameter int SCORE_WIDTH  = 4,
   parameter int WIN_SCORE    = 5,
   parameter int SERVE_FRAMES = 60,
   parameter int HOLD_FRAMES  = 90
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_end,
   input  logic                   start,
   input  logic                   goal_left,
   input  logic                   goal_right,
`ifdef PONG_PAUSE_EN
   input  logic                   pause,
`endif
   output logic                   ball_reset,
   output logic                   ball_run,
   output logic                   serve_dir,
   output logic [SCORE_WIDTH-1:0] p1_score,
   output logic [SCORE_WIDTH-1:0] p2_score,
   output logic [1:0]             winner,
   output logic [2:0]             state
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
   localparam int FC_W       = $clog2(MAX_FRAMES + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] SERVE = 3'd1;
   localparam logic [2:0] PLAY  = 3'd2;
   localparam logic [2:0] HOLD  = 3'd3;
   localparam logic [2:0] OVER  = 3'd4;

   localparam logic [FC_W-1:0]        SERVE_LAST = FC_W'(SERVE_FRAMES - 1);
   localparam logic [FC_W-1:0]        HOLD_LAST  = FC_W'(HOLD_FRAMES - 1);
   localparam logic [SCORE_WIDTH-1:0] WIN_VAL    = SCORE_WIDTH'(WIN_SCORE);

   logic                   frameEndQ;
   logic                   startQ;
   logic                   tick;
   logic                   go;
   logic                   runGate;
   logic [FC_W-1:0]        fc;

   logic [2:0]             stateNxt;
   logic [FC_W-1:0]        fcNxt;
   logic [SCORE_WIDTH-1:0] p1Nxt;
   logic [SCORE_WIDTH-1:0] p2Nxt;
   logic [1:0]             winNxt;
   logic                   dirNxt;
   logic                   ballResetNxt;

`ifdef PONG_PAUSE_EN
   // Pause swallows ticks only; start edges still reach IDLE/OVER.
   assign tick    = frame_end & ~frameEndQ & ~pause;
   assign runGate = ~pause;
`else
   assign tick    = frame_end & ~frameEndQ;
   assign runGate = 1'b1;
`endif
   assign go = start & ~startQ;

   always_comb begin
      stateNxt     = state;
      fcNxt        = fc;
      p1Nxt        = p1_score;
      p2Nxt        = p2_score;
      winNxt       = winner;
      dirNxt       = serve_dir;
      ballResetNxt = 1'b0;
      case (state)
         IDLE, OVER: begin
            if (go) begin
               p1Nxt        = '0;
               p2Nxt        = '0;
               winNxt       = 2'd0;
               fcNxt        = '0;
               ballResetNxt = 1'b1;
               stateNxt     = SERVE;
            end
         end
         SERVE: begin
            if (tick) begin
               if (fc == SERVE_LAST) begin
                  fcNxt    = '0;
                  stateNxt = PLAY;
               end else begin
                  fcNxt = fc + 1'b1;
               end
            end
         end
         PLAY: begin
            if (tick) begin
               if (goal_left && goal_right) begin
                  ballResetNxt = 1'b1;
                  fcNxt        = '0;
                  stateNxt     = SERVE;
               end else if (goal_right) begin
                  p1Nxt  = p1_score + 1'b1;
                  dirNxt = 1'b1;
                  if (p1Nxt == WIN_VAL) begin
                     winNxt   = 2'd1;
                     stateNxt = OVER;
                  end else begin
                     fcNxt    = '0;
                     stateNxt = HOLD;
                  end
               end else if (goal_left) begin
                  p2Nxt  = p2_score + 1'b1;
                  dirNxt = 1'b0;
                  if (p2Nxt == WIN_VAL) begin
                     winNxt   = 2'd2;
                     stateNxt = OVER;
                  end else begin
                     fcNxt    = '0;
                     stateNxt = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               if (fc == HOLD_LAST) begin
                  fcNxt        = '0;
                  ballResetNxt = 1'b1;
                  stateNxt     = SERVE;
               end else begin
                  fcNxt = fc + 1'b1;
               end
            end
         end
         default: begin
            fcNxt    = '0;
            stateNxt = IDLE;
         end
      endcase
   end

   // Edge registers track the inputs even in reset so a held level never fires on release.
   always_ff @(posedge clk) begin
      frameEndQ <= frame_end;
      startQ    <= start;
      if (!reset) begin
         state      <= IDLE;
         fc         <= '0;
         p1_score   <= '0;
         p2_score   <= '0;
         winner     <= 2'd0;
         serve_dir  <= 1'b0;
         ball_reset <= 1'b0;
         ball_run   <= 1'b0;
      end else begin
         state      <= stateNxt;
         fc         <= fcNxt;
         p1_score   <= p1Nxt;
         p2_score   <= p2Nxt;
         winner     <= winNxt;
         serve_dir  <= dirNxt;
         ball_reset <= ballResetNxt;
         ball_run   <= (stateNxt == PLAY) && runGate;
      end
   end

endmodule

// File: tb/tb_pong_round_ctrl.sv
// Randomized bench for pong_round_ctrl against a frame-countdown model of the round rules.
module tb_pong_round_ctrl;

   localparam int SW       = 4;
   localparam int WIN      = 5;
   localparam int N_SERVE  = 60;
   localparam int N_HOLD   = 90;
   localparam int NCYC     = 60000;

   localparam int P_IDLE  = 0;
   localparam int P_SERVE = 1;
   localparam int P_PLAY  = 2;
   localparam int P_HOLD  = 3;
   localparam int P_OVER  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          frame_end;
   logic          start;
   logic          goal_left;
   logic          goal_right;
   logic          pause;
   logic          ball_reset;
   logic          ball_run;
   logic          serve_dir;
   logic [SW-1:0] p1_score;
   logic [SW-1:0] p2_score;
   logic [1:0]    winner;
   logic [2:0]    state;

   pong_round_ctrl #(
      .SCORE_WIDTH (SW),
      .WIN_SCORE   (WIN),
      .SERVE_FRAMES(N_SERVE),
      .HOLD_FRAMES (N_HOLD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_end  (frame_end),
      .start      (start),
      .goal_left  (goal_left),
      .goal_right (goal_right),
`ifdef PONG_PAUSE_EN
      .pause      (pause),
`endif
      .ball_reset (ball_reset),
      .ball_run   (ball_run),
      .serve_dir  (serve_dir),
      .p1_score   (p1_score),
      .p2_score   (p2_score),
      .winner     (winner),
      .state      (state)
   );

   always #5 clk = ~clk;

   int assertCnt = 0;
   int failCnt   = 0;
   int cycNow    = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycNow);
      end
   endtask

   // Reference: phase plus frames remaining in the current wait, counted down.
   int mPhase, mLeft, mP1, mP2, mWin, mDir, mBallReset, mRun;
   int mPrevFrame, mPrevStart;
   int sawOver = 0;
   int sawLet  = 0;

   task automatic modelStep(input logic rst, input logic fe, input logic st,
                            input logic gl, input logic gr, input logic ps);
      bit tk, gv;
      if (!rst) begin
         mPhase = P_IDLE; mLeft = 0; mP1 = 0; mP2 = 0; mWin = 0; mDir = 0;
         mBallReset = 0; mRun = 0;
         mPrevFrame = fe; mPrevStart = st;
         return;
      end
      tk = fe && !mPrevFrame && !ps;
      gv = st && !mPrevStart;
      mPrevFrame = fe;
      mPrevStart = st;
      mBallReset = 0;
      case (mPhase)
         P_IDLE, P_OVER: if (gv) begin
            mP1 = 0; mP2 = 0; mWin = 0;
            mPhase = P_SERVE; mLeft = N_SERVE; mBallReset = 1;
         end
         P_SERVE: if (tk) begin
            mLeft--;
            if (mLeft == 0) mPhase = P_PLAY;
         end
         P_PLAY: if (tk) begin
            if (gl && gr) begin
               sawLet++;
               mPhase = P_SERVE; mLeft = N_SERVE; mBallReset = 1;
            end else if (gl || gr) begin
               if (gr) begin mP1++; mDir = 1; end
               else    begin mP2++; mDir = 0; end
               if (mP1 == WIN || mP2 == WIN) begin
                  mWin = (mP1 == WIN) ? 1 : 2;
                  mPhase = P_OVER;
                  sawOver++;
               end else begin
                  mPhase = P_HOLD; mLeft = N_HOLD;
               end
            end
         end
         P_HOLD: if (tk) begin
            mLeft--;
            if (mLeft == 0) begin
               mPhase = P_SERVE; mLeft = N_SERVE; mBallReset = 1;
            end
         end
         default: mPhase = P_IDLE;
      endcase
      mRun = (mPhase == P_PLAY) && !ps;
   endtask

   initial begin
      int r;
      reset = 1'b0; start = 1'b1; frame_end = 1'b0;
      goal_left = 1'b0; goal_right = 1'b0; pause = 1'b0;
      modelStep(reset, frame_end, start, goal_left, goal_right, pause);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         cycNow = cyc;
         checkVal("state",      state,      mPhase);
         checkVal("ball_reset", ball_reset, mBallReset);
         checkVal("ball_run",   ball_run,   mRun);
         checkVal("serve_dir",  serve_dir,  mDir);
         checkVal("p1_score",   p1_score,   mP1);
         checkVal("p2_score",   p2_score,   mP2);
         checkVal("winner",     winner,     mWin);

         // Start held high through reset and release: no edge may be seen.
         if (cyc < 14) begin
            reset = (cyc >= 4);
            start = 1'b1;
         end else begin
            reset = !((cyc >= 21000 && cyc < 21003) || (cyc >= 47000 && cyc < 47002)
                      || ($urandom_range(0, 49999) == 0));
            if ($urandom_range(0, 7) == 0) start = ~start;
         end
         if ($urandom_range(0, 3) != 0) frame_end = ~frame_end;
         r = $urandom_range(0, 15);
         goal_left  = (r == 0) || (r == 3) || (r == 4);
         goal_right = (r <= 2);
`ifdef PONG_PAUSE_EN
         if ($urandom_range(0, 63) == 0) pause = ~pause;
`endif
         modelStep(reset, frame_end, start, goal_left, goal_right, pause);
      end
      checkVal("cover_game_over", (sawOver > 0), 1);
      checkVal("cover_let",       (sawLet > 0),  1);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/pong_round_ctrl.md
Name: pong_round_ctrl

Overview:
Game-round sequencer for the two-player VGA paddle game. It consumes the frame-boundary strobe from the timing generator and the goal-strip hit flags. It decides when the ball is recentred, when it moves, and who scores. It owns both score counters, the serve direction and the winner code that feeds the 7-segment decoder.

Parameters:
SCORE_WIDTH, 4, width of each player score counter
WIN_SCORE, 5, points needed to win a game (1..2^SCORE_WIDTH-1)
SERVE_FRAMES, 60, frames the ball sits recentred before moving
HOLD_FRAMES, 90, frames of post-point pause before the next serve

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-low reset
frame_end  in  1  level from timing generator, high between frames; rising edge = one frame tick
start  in  1  start/restart button, level; rising edge used
goal_left  in  1  ball overlaps left goal strip (point to P2), level
goal_right  in  1  ball overlaps right goal strip (point to P1), level
ball_reset  out  1  one-clk pulse: load ball to centre (320,240)
ball_run  out  1  high while ball position may advance
serve_dir  out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
p1_score  out  SCORE_WIDTH  player 1 points
p2_score  out  SCORE_WIDTH  player 2 points
winner  out  2  0 none, 1 P1, 2 P2 (3 never driven)
state  out  3  current FSM state code, for debug LEDs

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=IDLE; all counters 0; ball_reset=0; ball_run=0; serve_dir=0; winner=0.
  - Edge-detect registers are loaded with the current input values, so a level already high at reset release does not fire an edge.
- Edge detects:
  - tick = frame_end & ~frame_end_q.
  - go = start & ~start_q.
  - Both are one clk wide. All FSM actions below happen on the clk edge where tick or go is 1. Outputs are registered and visible the following cycle.
- Frame counter fc: width $clog2(max(SERVE_FRAMES,HOLD_FRAMES)+1).
- States and codes: IDLE=0, SERVE=1, PLAY=2, HOLD=3, OVER=4.
- IDLE:
  - ball_run=0.
  - On go: scores=0, winner=0, fc=0, ball_reset pulse, go to SERVE.
- SERVE:
  - ball_run=0.
  - Each tick increments fc. On the tick that makes fc==SERVE_FRAMES: fc=0, go to PLAY.
  - Goal flags are ignored.
- PLAY:
  - ball_run=1.
  - Goal flags are sampled only on tick.
  - goal_right only: p1_score+1, serve_dir=1 (toward the point loser).
  - goal_left only: p2_score+1, serve_dir=0.
  - Both high on the same tick: a let. No score, ball_reset pulse, fc=0, go to SERVE, serve_dir unchanged.
  - After a score: if the new score == WIN_SCORE, winner=1/2 and go to OVER. Otherwise fc=0 and go to HOLD.
  - ball_run drops the cycle after the scoring tick.
- HOLD:
  - ball_run=0.
  - Count ticks as in SERVE, up to HOLD_FRAMES. At the end: ball_reset pulse, fc=0, go to SERVE.
- OVER:
  - ball_run=0; scores and winner frozen.
  - On go: behave exactly as the IDLE→SERVE transition (clear, pulse, SERVE).
- Event priority:
  - go is ignored in SERVE, PLAY and HOLD.
  - tick and go on the same clk in IDLE/OVER: go wins and the tick is not counted.
- Overflow and idle counting:
  - Scores never exceed WIN_SCORE, so no wrap.
  - fc never exceeds the terminal value.
  - fc does not count in IDLE or OVER.
- ball_reset is exactly one clk high per transition into SERVE. It is never high in other cycles.
- Reset mid-game (any state): next cycle matches the post-reset values above. A pending tick or edge is discarded.

Optional Feature:
- Macro: PONG_PAUSE_EN. It adds input port pause (level).
- With the macro defined:
  - While pause==1, ticks are ignored in every state: fc frozen, goals not sampled, ball_run forced 0.
  - go is still honoured in IDLE/OVER.
  - Releasing pause resumes from the same state and fc.
- Without the macro: no pause port, no gating logic.

Test Plan:
- Reset with start held high, then release reset and keep start high → no transition; state=0, all outputs 0.
- start edge, then 60 ticks → ball_reset one pulse at entry; state=1 through tick 59; state=2 and ball_run=1 after tick 60.
- In PLAY, goal_right on a tick → p1_score=1, serve_dir=1, state=3. After 90 ticks → ball_reset pulse, state=1.
- goal_left and goal_right together on a tick → scores unchanged, ball_reset pulse, state=1, serve_dir unchanged.
- Drive P2 to 5 points → winner=2, state=4, ball_run=0. Further ticks/goals change nothing. A start edge clears scores and winner and enters SERVE.
- With PONG_PAUSE_EN defined: pause high for 20 ticks mid-SERVE at fc=30 → fc stays 30. After release, PLAY is entered 30 ticks later.
